led_scan_controller: RTL and testbench

Time-multiplexed scan controller for the four-digit seven-segment display. Sequences the shared segment decoder across the four digits by driving one 4-bit character and one active-low anode at a time, and inserts a blanking gap at every digit switch to suppress ghosting. Sits between the value-producing logic and the decoder/anode pins, clocked from the divided display clock. Display data is double-buffered so that it only changes on frame boundaries.

---
 rtl/led_scan_controller.sv | 145 ++++++++++++++
 tb/tb_led_scan_controller.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_scan_controller.sv
// Four-digit seven-segment scan controller with per-slot blanking and frame-synchronous double-buffered data.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses anodes of leading zero digits.
module led_scan_controller #(
    parameter int unsigned REFRESH_DIV  = 3125,
    parameter int unsigned BLANK_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    output logic [3:0]  char,
    output logic        an3,
    output logic        an2,
    output logic        an1,
    output logic        an0,
    output logic        dp,
    output logic        frame_done
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DP_W   = 4;
    localparam int unsigned BUF_W  = DATA_W + DP_W;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [1:0]         idx, idx_nxt;
    logic [BUF_W-1:0]   shadow, shadow_nxt;
    logic [BUF_W-1:0]   display, display_nxt;
    logic               pending, pending_nxt;

    logic [3:0]         char_nxt;
    logic [3:0]         an, an_nxt;
    logic               dp_nxt;
    logic               frame_done_nxt;
    logic               frame_end;
    logic [3:0]         lz_blank;
    logic [DP_W-1:0]    dp_bits;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= BLANK;
            cnt        <= '0;
            idx        <= 2'd3;
            shadow     <= '0;
            display    <= '0;
            pending    <= 1'b0;
            char       <= 4'h0;
            an         <= 4'b1111;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            shadow     <= shadow_nxt;
            display    <= display_nxt;
            pending    <= pending_nxt;
            char       <= char_nxt;
            an         <= an_nxt;
            dp         <= dp_nxt;
            frame_done <= frame_done_nxt;
        end
    end

    // Outputs are computed from next-state values so they line up with the slot position
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt + CNT_W'(1);
        idx_nxt        = idx;
        shadow_nxt     = shadow;
        display_nxt    = display;
        pending_nxt    = pending;
        frame_end      = (idx == 2'd0) && (cnt == SLOT_LAST);
        lz_blank       = 4'b0000;
        dp_bits        = '0;
        char_nxt       = 4'h0;
        an_nxt         = 4'b1111;
        dp_nxt         = 1'b1;
        frame_done_nxt = 1'b0;

        case (state)
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_nxt = SHOW;
                end
            end
            SHOW: begin
                if (cnt == SLOT_LAST) begin
                    cnt_nxt   = '0;
                    idx_nxt   = idx - 2'd1;
                    state_nxt = BLANK;
                end
            end
            default: begin
                state_nxt = BLANK;
            end
        endcase

        // Commit takes the pre-edge shadow; a load on the same edge stays pending
        if (frame_end) begin
            if (pending) begin
                display_nxt = shadow;
            end
            pending_nxt = load;
        end else if (load) begin
            pending_nxt = 1'b1;
        end
        if (load) begin
            shadow_nxt = {dp_in, data_in};
        end

`ifdef LEADING_ZERO_BLANK_EN
        lz_blank[3] = (display_nxt[15:12] == 4'h0) && !display_nxt[19];
        lz_blank[2] = lz_blank[3] && (display_nxt[11:8] == 4'h0) && !display_nxt[18];
        lz_blank[1] = lz_blank[2] && (display_nxt[7:4] == 4'h0) && !display_nxt[17];
`endif

        dp_bits  = display_nxt[BUF_W-1:DATA_W];
        char_nxt = display_nxt[{idx_nxt, 2'b00} +: 4];
        if (state_nxt == SHOW) begin
            if (!lz_blank[idx_nxt]) begin
                an_nxt[idx_nxt] = 1'b0;
            end
            dp_nxt = ~dp_bits[idx_nxt];
        end
        frame_done_nxt = (idx_nxt == 2'd0) && (cnt_nxt == SLOT_LAST);
    end

    assign an3 = an[3];
    assign an2 = an[2];
    assign an1 = an[1];
    assign an0 = an[0];

endmodule

// File: tb/tb_led_scan_controller.sv
// Self-checking bench for led_scan_controller: frame-position reference model plus literal spot checks.
module tb_led_scan_controller;

    localparam int R     = 8;
    localparam int B     = 2;
    localparam int FRAME = 4 * R;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        load;
    logic [3:0]  char;
    logic        an3, an2, an1, an0;
    logic        dp;
    logic        frame_done;
    logic [3:0]  an;

    int checks = 0;
    int errors = 0;

    led_scan_controller #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .load       (load),
        .char       (char),
        .an3        (an3),
        .an2        (an2),
        .an1        (an1),
        .an0        (an0),
        .dp         (dp),
        .frame_done (frame_done)
    );

    assign an = {an3, an2, an1, an0};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: cycle position since reset plus committed/shadow/pending data
    bit          started = 1'b0;
    int          t = 0;
    logic [19:0] m_disp = '0;
    logic [19:0] m_shadow = '0;
    bit          m_pending = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            t         = 0;
            m_disp    = '0;
            m_shadow  = '0;
            m_pending = 1'b0;
            started   = 1'b1;
        end else if (started) begin
            if (t % FRAME == FRAME - 1) begin
                if (m_pending) m_disp = m_shadow;
                m_pending = load;
            end else if (load) begin
                m_pending = 1'b1;
            end
            if (load) m_shadow = {dp_in, data_in};
            t++;
        end
    end

    // Per-cycle comparison against the model
    int          c_pos, c_dig, c_off;
    bit          c_lit;
    logic [3:0]  e_an, e_char;
    logic        e_dp;
    always @(negedge clk) begin
        if (started) begin
            c_pos  = t % FRAME;
            c_dig  = 3 - c_pos / R;
            c_off  = c_pos % R;
            e_char = 4'(m_disp[15:0] >> (4 * c_dig));
            c_lit  = 1'b1;
            if (LZB && c_dig != 0)
                c_lit = ((m_disp[15:0] >> (4 * c_dig)) != 0) || ((m_disp[19:16] >> c_dig) != 0);
            e_an = 4'b1111;
            e_dp = 1'b1;
            if (c_off >= B) begin
                if (c_lit) e_an[c_dig] = 1'b0;
                e_dp = ~m_disp[16 + c_dig];
            end
            check("an", 32'(an), 32'(e_an));
            check("char", 32'(char), 32'(e_char));
            check("dp", 32'(dp), 32'(e_dp));
            check("frame_done", 32'(frame_done), 32'(c_pos == FRAME - 1));
            check("cnt", 32'(dut.cnt), 32'(c_off));
            check("idx", 32'(dut.idx), 32'(c_dig));
            check("one_anode", 32'($countones(~an) <= 1), 32'd1);
            if (c_off < B) check("blank_anodes", 32'(an), 32'hF);
        end
    end

    task automatic step_to(input int n);
        int g = 0;
        while (t != n && g < 1000) begin
            @(negedge clk);
            g++;
        end
        check("reach_cycle", 32'(t), 32'(n));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load_at(input int n, input logic [15:0] d, input logic [3:0] p);
        step_to(n);
        data_in = d;
        dp_in   = p;
        load    = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        load    = 1'b0;
        data_in = '0;
        dp_in   = '0;
        @(negedge clk);
        @(negedge clk);

        // Scan timing, reset values and a basic load
        do_reset();
        check("rst_an", 32'(an), 32'hF);
        check("rst_dp", 32'(dp), 32'd1);
        check("rst_char", 32'(char), 32'd0);
        check("rst_fd", 32'(frame_done), 32'd0);
        step_to(2);
        check("c2_an", 32'(an), LZB ? 32'hF : 32'h7);
        load_at(5, 16'h1234, 4'b0100);
        step_to(8);
        check("c8_an", 32'(an), 32'hF);
        step_to(10);
        check("c10_an", 32'(an), LZB ? 32'hF : 32'hB);
        step_to(20);
        check("c20_char", 32'(char), 32'd0);
        step_to(30);
        check("c30_fd", 32'(frame_done), 32'd0);
        step_to(31);
        check("c31_fd", 32'(frame_done), 32'd1);
        step_to(34);
        check("c34_char", 32'(char), 32'h1);
        check("c34_an", 32'(an), 32'h7);
        check("c34_dp", 32'(dp), 32'd1);
        step_to(42);
        check("c42_char", 32'(char), 32'h2);
        check("c42_an", 32'(an), 32'hB);
        check("c42_dp", 32'(dp), 32'd0);
        step_to(50);
        check("c50_char", 32'(char), 32'h3);
        check("c50_an", 32'(an), 32'hD);
        step_to(58);
        check("c58_char", 32'(char), 32'h4);
        check("c58_an", 32'(an), 32'hE);

        // Last load wins; load on frame end commits one frame later
        do_reset();
        load_at(3, 16'hAAAA, 4'b0000);
        load_at(20, 16'hBEEF, 4'b0000);
        step_to(31);
        check("s2_fd", 32'(frame_done), 32'd1);
        load_at(31, 16'h5555, 4'b0000);
        step_to(34);
        check("f2_d3", 32'(char), 32'hB);
        step_to(42);
        check("f2_d2", 32'(char), 32'hE);
        step_to(58);
        check("f2_d0", 32'(char), 32'hF);
        step_to(66);
        check("f3_d3", 32'(char), 32'h5);

        // Reset in the middle of digit 2's show period
        do_reset();
        load_at(5, 16'h1234, 4'b0000);
        step_to(45);
        check("pre_rst_char", 32'(char), 32'h2);
        do_reset();
        check("mid_rst_an", 32'(an), 32'hF);
        check("mid_rst_char", 32'(char), 32'd0);
        check("mid_rst_idx", 32'(dut.idx), 32'd3);
        check("mid_rst_cnt", 32'(dut.cnt), 32'd0);
        step_to(2);
        check("mid_rst_c2_char", 32'(char), 32'd0);
        check("mid_rst_c2_an", 32'(an), LZB ? 32'hF : 32'h7);

        // Leading-zero handling
        do_reset();
        load_at(5, 16'h0040, 4'b0000);
        step_to(34);
        check("lz_d3_an", 32'(an), LZB ? 32'hF : 32'h7);
        step_to(42);
        check("lz_d2_an", 32'(an), LZB ? 32'hF : 32'hB);
        step_to(50);
        check("lz_d1_an", 32'(an), 32'hD);
        check("lz_d1_char", 32'(char), 32'h4);
        step_to(58);
        check("lz_d0_an", 32'(an), 32'hE);
        check("lz_d0_char", 32'(char), 32'h0);

        // Random loads over four frames
        do_reset();
        for (int i = 0; i < 4 * FRAME; i++) begin
            load    = ($urandom_range(0, 4) == 0);
            data_in = 16'($urandom);
            dp_in   = 4'($urandom);
            @(negedge clk);
        end

        // Random loads, sparse data and occasional resets
        for (int i = 0; i < 6 * FRAME; i++) begin
            reset   = ($urandom_range(0, 79) == 0);
            load    = ($urandom_range(0, 5) == 0);
            data_in = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            dp_in   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            @(negedge clk);
        end
        reset = 1'b0;
        load  = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
